// File: rtl/sda_dispatch_pkg.sv
// Shared types and limits for the SDA kernel dispatcher.
// Slot state encoding and legal slot-count range.
package sda_dispatch_pkg;

    typedef enum logic [1:0] {
        SlotIdle   = 2'd0,
        SlotLaunch = 2'd1,
        SlotRun    = 2'd2,
        SlotDone   = 2'd3
    } slot_state_e;

    localparam int MinNumSlots = 2;
    localparam int MaxNumSlots = 16;

endpackage

// File: rtl/sda_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr.
// Wraps with an explicit compare so non-power-of-two N works.
module sda_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        logic [W-1:0] c;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = ptr;
        for (int i = 0; i < N; i++) begin
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = c;
            end
            c = (c == W'(N - 1)) ? '0 : c + 1'b1;
        end
    end

endmodule

// File: rtl/sda_kernel_dispatcher.sv
// Round-robin kernel launch dispatcher over NumSlots reset handlers.
// Optional per-slot watchdog: define SDA_DISPATCH_WATCHDOG_EN.
module sda_kernel_dispatcher
    import sda_dispatch_pkg::*;
#(
    parameter int NumSlots = 4,
    parameter int WatchdogCountSize = 16,
    localparam int SlotIdWidth = $clog2(NumSlots)
) (
    input  logic                   clk,
    input  logic                   sysRstN,
    input  logic                   regGoValid,
    output logic                   regGoHoldoff,
    output logic                   regDoneValid,
    input  logic                   regDoneStop,
    output logic [SlotIdWidth-1:0] regDoneSlot,
    output logic                   regDoneFault,
    output logic [NumSlots-1:0]    slotGoValid,
    input  logic [NumSlots-1:0]    slotGoHoldoff,
    input  logic [NumSlots-1:0]    slotDoneValid,
    output logic [NumSlots-1:0]    slotDoneStop,
    output logic [NumSlots-1:0]    slotBusy
);

    if (NumSlots < MinNumSlots || NumSlots > MaxNumSlots) begin : g_bad_slots
        $error("sda_kernel_dispatcher: NumSlots out of range");
    end

    slot_state_e slot_q [NumSlots];
    slot_state_e slot_d [NumSlots];

    logic                   rst_done_q;
    logic                   go_holdoff_q, go_holdoff_d;
    logic [SlotIdWidth-1:0] go_ptr_q, go_ptr_d;
    logic [SlotIdWidth-1:0] done_ptr_q, done_ptr_d;
    logic                   done_valid_q, done_valid_d;
    logic [SlotIdWidth-1:0] done_slot_q, done_slot_d;

    logic [NumSlots-1:0]    idle_mask, done_mask, go_gnt, done_gnt;
    logic [SlotIdWidth-1:0] go_idx, done_idx;
    logic                   go_any, done_any, go_acc, done_xfer;

`ifdef SDA_DISPATCH_WATCHDOG_EN
    localparam logic [WatchdogCountSize-1:0] WdLast =
        {{(WatchdogCountSize-1){1'b1}}, 1'b0};
    logic [WatchdogCountSize-1:0] wd_q [NumSlots];
    logic [WatchdogCountSize-1:0] wd_d [NumSlots];
    logic [NumSlots-1:0] fault_q, fault_d;
    logic                done_fault_q, done_fault_d;
`else
    logic [WatchdogCountSize-1:0] unused_wd;
    logic                         unused_gnt;
    assign unused_wd  = '0;
    assign unused_gnt = ^done_gnt;
`endif

    always_comb begin
        for (int s = 0; s < NumSlots; s++) begin
            idle_mask[s]    = slot_q[s] == SlotIdle;
            done_mask[s]    = slot_q[s] == SlotDone;
            slotBusy[s]     = slot_q[s] != SlotIdle;
            slotGoValid[s]  = slot_q[s] == SlotLaunch;
            slotDoneStop[s] = slot_q[s] != SlotRun;
        end
    end

    sda_rr_arbiter #(.N(NumSlots), .W(SlotIdWidth)) u_go_arb (
        .req(idle_mask), .ptr(go_ptr_q),
        .gnt(go_gnt), .idx(go_idx), .any(go_any)
    );

    sda_rr_arbiter #(.N(NumSlots), .W(SlotIdWidth)) u_done_arb (
        .req(done_mask), .ptr(done_ptr_q),
        .gnt(done_gnt), .idx(done_idx), .any(done_any)
    );

    always_comb begin
        go_acc       = regGoValid && !go_holdoff_q;
        done_xfer    = done_valid_q && !regDoneStop;
        // Holdoff is a cycle behind the idle set, so grants are spaced >= 2 cycles.
        go_holdoff_d = !(rst_done_q && go_any && !go_acc);
        go_ptr_d     = go_ptr_q;
        if (go_acc) begin
            go_ptr_d = (go_idx == SlotIdWidth'(NumSlots - 1)) ? '0 : go_idx + 1'b1;
        end

        done_valid_d = done_valid_q;
        done_slot_d  = done_slot_q;
        done_ptr_d   = done_ptr_q;
`ifdef SDA_DISPATCH_WATCHDOG_EN
        done_fault_d = done_fault_q;
`endif
        if (done_xfer) begin
            done_valid_d = 1'b0;
            done_ptr_d   = (done_slot_q == SlotIdWidth'(NumSlots - 1)) ?
                           '0 : done_slot_q + 1'b1;
        end else if (!done_valid_q && done_any) begin
            done_valid_d = 1'b1;
            done_slot_d  = done_idx;
`ifdef SDA_DISPATCH_WATCHDOG_EN
            done_fault_d = |(done_gnt & fault_q);
`endif
        end

        for (int s = 0; s < NumSlots; s++) begin
            slot_d[s] = slot_q[s];
`ifdef SDA_DISPATCH_WATCHDOG_EN
            wd_d[s]    = wd_q[s];
            fault_d[s] = fault_q[s];
`endif
            unique case (slot_q[s])
                SlotIdle: begin
                    if (go_acc && go_gnt[s]) slot_d[s] = SlotLaunch;
                end
                SlotLaunch: begin
                    if (!slotGoHoldoff[s]) begin
                        slot_d[s] = SlotRun;
`ifdef SDA_DISPATCH_WATCHDOG_EN
                        wd_d[s]    = '0;
                        fault_d[s] = 1'b0;
`endif
                    end
                end
                SlotRun: begin
`ifdef SDA_DISPATCH_WATCHDOG_EN
                    wd_d[s] = wd_q[s] + 1'b1;
`endif
                    if (slotDoneValid[s]) begin
                        slot_d[s] = SlotDone;
                    end
`ifdef SDA_DISPATCH_WATCHDOG_EN
                    else if (wd_q[s] == WdLast) begin
                        slot_d[s]  = SlotDone;
                        fault_d[s] = 1'b1;
                    end
`endif
                end
                SlotDone: begin
                    if (done_xfer && done_slot_q == SlotIdWidth'(s)) begin
                        slot_d[s] = SlotIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge sysRstN) begin
        if (!sysRstN) begin
            rst_done_q   <= 1'b0;
            go_holdoff_q <= 1'b1;
            go_ptr_q     <= '0;
            done_ptr_q   <= '0;
            done_valid_q <= 1'b0;
            done_slot_q  <= '0;
            for (int s = 0; s < NumSlots; s++) slot_q[s] <= SlotIdle;
        end else begin
            rst_done_q   <= 1'b1;
            go_holdoff_q <= go_holdoff_d;
            go_ptr_q     <= go_ptr_d;
            done_ptr_q   <= done_ptr_d;
            done_valid_q <= done_valid_d;
            done_slot_q  <= done_slot_d;
            for (int s = 0; s < NumSlots; s++) slot_q[s] <= slot_d[s];
        end
    end

`ifdef SDA_DISPATCH_WATCHDOG_EN
    always_ff @(posedge clk or negedge sysRstN) begin
        if (!sysRstN) begin
            fault_q      <= '0;
            done_fault_q <= 1'b0;
            for (int s = 0; s < NumSlots; s++) wd_q[s] <= '0;
        end else begin
            fault_q      <= fault_d;
            done_fault_q <= done_fault_d;
            for (int s = 0; s < NumSlots; s++) wd_q[s] <= wd_d[s];
        end
    end

    assign regDoneFault = done_fault_q;
`else
    assign regDoneFault = 1'b0;
`endif

    assign regGoHoldoff = go_holdoff_q;
    assign regDoneValid = done_valid_q;
    assign regDoneSlot  = done_slot_q;

endmodule

// File: tb/tb_sda_kernel_dispatcher.sv
// Scoreboard bench for sda_kernel_dispatcher (4 slots).
// Watchdog scenario runs when SDA_DISPATCH_WATCHDOG_EN is defined.
module tb_sda_kernel_dispatcher;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         sysRstN;
    logic         regGoValid;
    logic         regGoHoldoff;
    logic         regDoneValid;
    logic         regDoneStop;
    logic [1:0]   regDoneSlot;
    logic         regDoneFault;
    logic [N-1:0] slotGoValid;
    logic [N-1:0] slotGoHoldoff;
    logic [N-1:0] slotDoneValid;
    logic [N-1:0] slotDoneStop;
    logic [N-1:0] slotBusy;

    int n_pass  = 0;
    int n_total = 0;
    int go_q[$];
    int done_q[$];

    always #5 clk = ~clk;

    sda_kernel_dispatcher #(.NumSlots(N), .WatchdogCountSize(4)) dut (
        .clk(clk), .sysRstN(sysRstN),
        .regGoValid(regGoValid), .regGoHoldoff(regGoHoldoff),
        .regDoneValid(regDoneValid), .regDoneStop(regDoneStop),
        .regDoneSlot(regDoneSlot), .regDoneFault(regDoneFault),
        .slotGoValid(slotGoValid), .slotGoHoldoff(slotGoHoldoff),
        .slotDoneValid(slotDoneValid), .slotDoneStop(slotDoneStop),
        .slotBusy(slotBusy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Monitor: slot launches and upstream completions against the queues.
    always @(negedge clk) begin
        if (sysRstN) begin
            for (int s = 0; s < N; s++) begin
                if (slotGoValid[s] && !slotGoHoldoff[s]) begin
                    if (go_q.size() == 0) chk("go_unexpected", s, -1);
                    else chk("go_slot", s, go_q.pop_front());
                end
            end
            if (regDoneValid && !regDoneStop) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", int'(regDoneSlot), -1);
                end else begin
                    int e;
                    e = done_q.pop_front();
                    chk("done_slot", int'(regDoneSlot), e / 2);
                    chk("done_fault", int'(regDoneFault), e % 2);
                end
            end
        end
    end

    task automatic issue_go(input int exp_slot);
        int n;
        n = 0;
        go_q.push_back(exp_slot);
        @(posedge clk);
        #1 regGoValid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (regGoHoldoff && n < 50);
        if (regGoHoldoff) chk("go_accept_timeout", 1, 0);
        @(posedge clk);
        #1 regGoValid = 1'b0;
    endtask

    task automatic finish_slots(input logic [N-1:0] m);
        @(posedge clk);
        #1 slotDoneValid = m;
        @(posedge clk);
        #1 slotDoneValid = '0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((go_q.size() != 0 || done_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, go_q.size() + done_q.size(), 0);
    endtask

    task automatic release_check(input string nm);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_holdoff_edge1"}, int'(regGoHoldoff), 1);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_holdoff_edge2"}, int'(regGoHoldoff), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        sysRstN       = 1'b0;
        regGoValid    = 1'b0;
        regDoneStop   = 1'b0;
        slotGoHoldoff = '0;
        slotDoneValid = '0;
        repeat (3) @(negedge clk);
        chk("rst_go_holdoff", int'(regGoHoldoff), 1);
        chk("rst_done_valid", int'(regDoneValid), 0);
        chk("rst_done_slot", int'(regDoneSlot), 0);
        chk("rst_done_fault", int'(regDoneFault), 0);
        chk("rst_slot_go", int'(slotGoValid), 0);
        chk("rst_slot_stop", int'(slotDoneStop), 15);
        chk("rst_slot_busy", int'(slotBusy), 0);
        @(posedge clk);
        #1 sysRstN = 1'b1;
        release_check("rel");

        for (int e = 0; e < N; e++) issue_go(e);
        wait_drain("dispatch_drain");
        repeat (3) begin
            @(negedge clk);
            chk("full_holdoff", int'(regGoHoldoff), 1);
            chk("full_busy", int'(slotBusy), 15);
        end

        done_q.push_back(1 * 2);
        finish_slots(4'b0010);
        wait_drain("done1_drain");
        issue_go(1);
        wait_drain("redispatch1_drain");

        @(posedge clk);
        #1 regDoneStop = 1'b1;
        done_q.push_back(3 * 2);
        done_q.push_back(1 * 2);
        finish_slots(4'b1010);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(regDoneValid), 1);
            chk("bp_slot", int'(regDoneSlot), 3);
            chk("bp_busy3", int'(slotBusy[3]), 1);
        end
        @(posedge clk);
        #1 regDoneStop = 1'b0;
        wait_drain("pair_drain");

        @(negedge clk);
        chk("busy_before_rst", int'(slotBusy), 5);
        @(posedge clk);
        #1 sysRstN = 1'b0;
        #1;
        chk("midrst_busy", int'(slotBusy), 0);
        chk("midrst_stop", int'(slotDoneStop), 15);
        chk("midrst_go", int'(slotGoValid), 0);
        chk("midrst_holdoff", int'(regGoHoldoff), 1);
        chk("midrst_done_valid", int'(regDoneValid), 0);
        repeat (2) @(posedge clk);
        #1 sysRstN = 1'b1;
        release_check("rel2");
        issue_go(0);
        wait_drain("restart_drain");
        done_q.push_back(0 * 2);
        finish_slots(4'b0001);
        wait_drain("restart_done_drain");

`ifdef SDA_DISPATCH_WATCHDOG_EN
        begin
            int cnt;
            int n;
            cnt = 0;
            n   = 0;
            done_q.push_back(1 * 2 + 1);
            issue_go(1);
            while (done_q.size() != 0 && n < 100) begin
                @(negedge clk);
                if (slotBusy[1] && !slotDoneStop[1]) cnt++;
                n++;
            end
            chk("wd_run_cycles", cnt, 15);
            @(negedge clk);
            chk("wd_slot1_idle", int'(slotBusy[1]), 0);
            done_q.push_back(2 * 2 + 1);
            done_q.push_back(3 * 2 + 1);
            done_q.push_back(0 * 2 + 1);
            done_q.push_back(1 * 2 + 1);
            issue_go(2);
            issue_go(3);
            issue_go(0);
            issue_go(1);
            wait_drain("wd_redispatch_drain");
        end
`endif

        repeat (2) @(negedge clk);
        chk("queues_empty", go_q.size() + done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sda_kernel_dispatcher.md
# sda_kernel_dispatcher

Schedules kernel launches across `NumSlots` parallel kernel instances, each behind its own kernel reset handler. Upstream it terminates the single register-block go/done handshake pair. Each accepted go request goes to an idle slot chosen round-robin. Completions are collected from the slots and returned upstream one at a time, tagged with the slot index. It sits between the control register block and the per-slot reset handlers.

## Interface
Parameters:
- `NumSlots`, 4, number of kernel slots, legal range 2..16.
- `SlotIdWidth`, derived as ceil(log2(`NumSlots`)), width of the slot index.
- `WatchdogCountSize`, 16, watchdog counter width; used only with the watchdog macro.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `sysRstN`  in  1  reset; asynchronous, active-low.
- `regGoValid`  in  1  go request from the register block.
- `regGoHoldoff`  out  1  go holdoff; a transfer happens when `regGoValid & ~regGoHoldoff`.
- `regDoneValid`  out  1  completion notification to the register block.
- `regDoneStop`  in  1  done stop; a transfer happens when `regDoneValid & ~regDoneStop`.
- `regDoneSlot`  out  `SlotIdWidth`  index of the completing slot; valid while `regDoneValid` is high.
- `regDoneFault`  out  1  completion was forced by the watchdog; tied 0 when the watchdog is compiled out.
- `slotGoValid`  out  `NumSlots`  per-slot go toward the slot's reset handler.
- `slotGoHoldoff`  in  `NumSlots`  per-slot go holdoff.
- `slotDoneValid`  in  `NumSlots`  per-slot done.
- `slotDoneStop`  out  `NumSlots`  per-slot done stop.
- `slotBusy`  out  `NumSlots`  high for every slot not in Idle.

## Operation
Per-slot state machine (`SlotIdle`, `SlotLaunch`, `SlotRun`, `SlotDone`):
- **SlotIdle → SlotLaunch:** on an upstream go accept granted to this slot.
- **SlotLaunch:** `slotGoValid[s]` is held high. Leaves for SlotRun in the cycle `slotGoValid[s] & ~slotGoHoldoff[s]`; `slotGoValid[s]` is low in the following cycle.
- **SlotRun:** `slotDoneStop[s]` is low. On `slotDoneValid[s] & ~slotDoneStop[s]` → SlotDone, and `slotDoneStop[s]` returns high in the following cycle.
- **SlotDone → SlotIdle:** when this slot's notification is accepted upstream.

Go accept:
- `regGoHoldoff` is registered. It is low in cycle t only if at least one slot was Idle in cycle t-1 and no accept occurred in cycle t-1. Peak throughput is therefore one go per two cycles.
- On accept, the slot is the first Idle slot at or after `goPtr`, wrapping modulo `NumSlots`.
- After the grant, `goPtr` becomes granted slot + 1, wrapping.

Done return:
- While `regDoneValid` is low, the first SlotDone slot at or after `donePtr` is latched into `regDoneSlot`/`regDoneFault`, and `regDoneValid` is raised in the next cycle.
- `regDoneSlot` and `regDoneFault` stay stable until the transfer completes.
- On transfer: that slot goes to Idle, `donePtr` becomes slot + 1, and `regDoneValid` drops for one cycle.

Boundary conditions:
- **All slots busy:** `regGoHoldoff` stays high.
- **Multiple slots finish in the same cycle:** every one is captured into SlotDone; they are reported in round-robin order.
- **Slot leaves SlotDone in cycle t:** it is not eligible for a go grant until cycle t+1.
- **`NumSlots` not a power of two:** pointer wrap uses explicit compare against `NumSlots`-1, not bit truncation.
- **Reset mid-operation:** all slots return to Idle immediately; any in-flight handshakes are abandoned. The per-slot reset handlers take their own system reset.

## Timing
Reset values (`sysRstN` low):
- `regGoHoldoff`=1, `regDoneValid`=0, `regDoneSlot`=0, `regDoneFault`=0.
- `slotGoValid`=0, `slotDoneStop`=all 1, `slotBusy`=0.
- `goPtr`=0, `donePtr`=0, watchdog counters=0.
- First possible `regGoHoldoff`=0 is the second rising edge after reset release.

Latencies:
- Upstream go accept → `slotGoValid[s]` high: 1 cycle.
- Slot done accept → `regDoneValid` high: 2 cycles, when `regDoneValid` was low and no other slot is pending.
- All outputs are registered.

## Configuration
- **`SDA_DISPATCH_WATCHDOG_EN` defined:**
  - Each slot has a `WatchdogCountSize`-bit counter, cleared on entry to SlotRun and incremented every SlotRun cycle.
  - If the counter reaches all-ones before `slotDoneValid[s]` is accepted, the slot enters SlotDone with a fault flag set. `slotDoneStop[s]` stays high afterwards.
  - The fault flag is reported as `regDoneFault`=1.
- **Undefined:** no counters exist, `regDoneFault` is constant 0, and SlotRun exits only on done.

## Structure
- Package `sda_dispatch_pkg` holds:
  - the slot state encoding (2 bits: SlotIdle=0, SlotLaunch=1, SlotRun=2, SlotDone=3);
  - the `NumSlots` range limits.
- One sub-module, `sda_rr_arbiter`, takes a request mask and a pointer and returns one-hot grant, grant index and any-grant. It is purely combinational and is instantiated twice: for go selection over the Idle mask and for done selection over the SlotDone mask.

## Test plan
- **Reset:** hold `sysRstN` low, then release → all outputs at reset values. `regGoHoldoff` goes 0 on the second edge after release.
- **Dispatch order:** 4 back-to-back go requests with `slotGoHoldoff`=0 → slots granted in order 0,1,2,3. `regGoHoldoff` stays 1 after the fourth grant.
- **Completion order:** slots 3 and 1 assert done in the same cycle with `donePtr`=2 → `regDoneSlot` reports 3 then 1. Slot 1 is reported only after `regDoneStop` releases slot 3.
- **Done backpressure:** `regDoneStop`=1 for 10 cycles → `regDoneValid`/`regDoneSlot` stable throughout. The slot stays busy until the transfer.
- **Watchdog:** with `SDA_DISPATCH_WATCHDOG_EN`, `WatchdogCountSize`=4, and a slot that never signals done → fault report after 15 SlotRun cycles with `regDoneFault`=1, and the slot is re-dispatchable.
- **Reset mid-run:** assert `sysRstN` low with 2 slots in SlotRun → `slotBusy`=0 and `slotDoneStop`=all 1 immediately. After release, dispatch restarts at slot 0.
